power_domain_sequencer: RTL and testbench

- Receives one domain's power-enable request from the power management controller (e.g. adc_power_enable or filter_power_enable) and performs the physical power-up/power-down sequence for that domain.
- Drives the rail switch, output isolation, domain clock enable and domain reset in a fixed safe order.
- Reports ready, fault and sequence-complete status back to the controller. One instance per switchable domain.

---
 rtl/power_domain_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_power_domain_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/power_domain_sequencer.sv
// -----------------------------------------------------------------------------
// power_domain_sequencer
//
// Sequences the power-up and power-down of one switchable power domain in
// response to a level request from the power management controller. The rail
// switch, output isolation, domain clock gate and domain reset are driven in a
// fixed safe order. Ready, fault and sequence-complete status are reported back.
//
// Ports:
//   clock            system clock
//   reset            synchronous, active-high reset (forces OFF)
//   power_enable_req level request: 1 = domain on, 0 = domain off
//   settle_cycles    minimum rail-ramp wait in cycles (0 is treated as 1)
//   rail_ok          rail-good comparator, already synchronised
//   power_switch_en  rail header switch on
//   isolation_en     clamp domain outputs
//   domain_clk_en    domain clock gate enable
//   domain_reset     domain reset, active-high
//   domain_ready     domain usable
//   fault            high while in FAULT
//   seq_done         one-cycle pulse on entry to ON or OFF (not on reset)
//   seq_state        current state encoding
//
// Every output is a flop loaded from a decode of the next state, so outputs
// always equal the Moore decode of the state register and there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module power_domain_sequencer #(
    parameter int unsigned RESET_CYCLES     = 3,
    parameter int unsigned DISCHARGE_CYCLES = 4,
    parameter int unsigned RAMP_TIMEOUT     = 64,
    parameter int unsigned CNT_W            = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       power_enable_req,
    input  logic [7:0] settle_cycles,
    input  logic       rail_ok,
    output logic       power_switch_en,
    output logic       isolation_en,
    output logic       domain_clk_en,
    output logic       domain_reset,
    output logic       domain_ready,
    output logic       fault,
    output logic       seq_done,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_RAMP       = 3'd1,
        ST_RESET_HOLD = 3'd2,
        ST_ON         = 3'd3,
        ST_ISOLATE    = 3'd4,
        ST_DRAIN      = 3'd5,
        ST_DISCHARGE  = 3'd6,
        ST_FAULT      = 3'd7
    } state_t;

    // Terminal counter values: the counter reads 0 on the first cycle of a
    // state, so a state lasting N cycles exits when the counter is N-1.
    localparam logic [CNT_W-1:0] RESET_LAST =
        CNT_W'((RESET_CYCLES > 0) ? RESET_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] DISCHARGE_LAST =
        CNT_W'((DISCHARGE_CYCLES > 0) ? DISCHARGE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] RAMP_LAST =
        CNT_W'((RAMP_TIMEOUT > 0) ? RAMP_TIMEOUT - 1 : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] settle_last;

    logic power_switch_en_q, power_switch_en_d;
    logic isolation_en_q,    isolation_en_d;
    logic domain_clk_en_q,   domain_clk_en_d;
    logic domain_reset_q,    domain_reset_d;
    logic domain_ready_q,    domain_ready_d;
    logic fault_q,           fault_d;
    logic seq_done_q,        seq_done_d;

    // Minimum ramp wait minus one, with settle_cycles = 0 behaving as 1.
    always_comb begin
        settle_last = '0;
        if (settle_cycles != 8'd0) begin
            settle_last = CNT_W'(settle_cycles - 8'd1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OFF: begin
                if (power_enable_req) begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (!power_enable_req) begin
                    state_d = ST_DISCHARGE;
                end else if ((cnt_q >= settle_last) && rail_ok) begin
                    state_d = ST_RESET_HOLD;
                end else if (cnt_q == RAMP_LAST) begin
                    state_d = ST_FAULT;
                end
            end
            ST_RESET_HOLD: begin
                // Abort goes through DRAIN so the clock is stopped before
                // the rail is switched off.
                if (!power_enable_req) begin
                    state_d = ST_DRAIN;
                end else if (cnt_q == RESET_LAST) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                // Brownout outranks a power-down request.
                if (!rail_ok) begin
                    state_d = ST_FAULT;
                end else if (!power_enable_req) begin
                    state_d = ST_ISOLATE;
                end
            end
            ST_ISOLATE: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_d = ST_DISCHARGE;
            end
            ST_DISCHARGE: begin
                // The request is deliberately ignored: the rail always
                // discharges fully and any new request restarts from OFF.
                if (cnt_q == DISCHARGE_LAST) begin
                    state_d = ST_OFF;
                end
            end
            ST_FAULT: begin
                if (!power_enable_req) begin
                    state_d = ST_DISCHARGE;
                end
            end
        endcase
    end

    // Sequence counter: clears on every state entry, otherwise saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output decode of the next state, registered alongside the state.
    always_comb begin
        power_switch_en_d = 1'b0;
        isolation_en_d    = 1'b1;
        domain_clk_en_d   = 1'b0;
        domain_reset_d    = 1'b1;
        domain_ready_d    = 1'b0;
        fault_d           = 1'b0;
        unique case (state_d)
            ST_OFF: begin
            end
            ST_RAMP: begin
                power_switch_en_d = 1'b1;
            end
            ST_RESET_HOLD: begin
                power_switch_en_d = 1'b1;
                domain_clk_en_d   = 1'b1;
            end
            ST_ON: begin
                power_switch_en_d = 1'b1;
                isolation_en_d    = 1'b0;
                domain_clk_en_d   = 1'b1;
                domain_reset_d    = 1'b0;
                domain_ready_d    = 1'b1;
            end
            ST_ISOLATE: begin
                power_switch_en_d = 1'b1;
                domain_clk_en_d   = 1'b1;
                domain_reset_d    = 1'b0;
            end
            ST_DRAIN: begin
                power_switch_en_d = 1'b1;
            end
            ST_DISCHARGE: begin
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
        endcase
        seq_done_d = (state_d != state_q) &&
                     ((state_d == ST_ON) || (state_d == ST_OFF));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= ST_OFF;
            cnt_q             <= '0;
            power_switch_en_q <= 1'b0;
            isolation_en_q    <= 1'b1;
            domain_clk_en_q   <= 1'b0;
            domain_reset_q    <= 1'b1;
            domain_ready_q    <= 1'b0;
            fault_q           <= 1'b0;
            seq_done_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            power_switch_en_q <= power_switch_en_d;
            isolation_en_q    <= isolation_en_d;
            domain_clk_en_q   <= domain_clk_en_d;
            domain_reset_q    <= domain_reset_d;
            domain_ready_q    <= domain_ready_d;
            fault_q           <= fault_d;
            seq_done_q        <= seq_done_d;
        end
    end

    assign power_switch_en = power_switch_en_q;
    assign isolation_en    = isolation_en_q;
    assign domain_clk_en   = domain_clk_en_q;
    assign domain_reset    = domain_reset_q;
    assign domain_ready    = domain_ready_q;
    assign fault           = fault_q;
    assign seq_done        = seq_done_q;
    assign seq_state       = state_q;

endmodule

// File: tb/tb_power_domain_sequencer.sv
// -----------------------------------------------------------------------------
// tb_power_domain_sequencer
//
// Inputs are driven on the falling edge; the state and seq_done expected after
// the following rising edge are pushed to a scoreboard queue, and a checker
// pops and compares them 1 time unit after that rising edge. Expected output
// pins are derived from the expected state using the state/output table.
// -----------------------------------------------------------------------------
module tb_power_domain_sequencer;

    localparam logic [2:0] S_OFF  = 3'd0;
    localparam logic [2:0] S_RAMP = 3'd1;
    localparam logic [2:0] S_RH   = 3'd2;
    localparam logic [2:0] S_ON   = 3'd3;
    localparam logic [2:0] S_ISO  = 3'd4;
    localparam logic [2:0] S_DRN  = 3'd5;
    localparam logic [2:0] S_DIS  = 3'd6;
    localparam logic [2:0] S_FLT  = 3'd7;

    logic       clock;
    logic       reset;
    logic       power_enable_req;
    logic [7:0] settle_cycles;
    logic       rail_ok;
    logic       power_switch_en;
    logic       isolation_en;
    logic       domain_clk_en;
    logic       domain_reset;
    logic       domain_ready;
    logic       fault;
    logic       seq_done;
    logic [2:0] seq_state;

    power_domain_sequencer #(
        .RESET_CYCLES    (3),
        .DISCHARGE_CYCLES(4),
        .RAMP_TIMEOUT    (64),
        .CNT_W           (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .power_enable_req(power_enable_req),
        .settle_cycles   (settle_cycles),
        .rail_ok         (rail_ok),
        .power_switch_en (power_switch_en),
        .isolation_en    (isolation_en),
        .domain_clk_en   (domain_clk_en),
        .domain_reset    (domain_reset),
        .domain_ready    (domain_ready),
        .fault           (fault),
        .seq_done        (seq_done),
        .seq_state       (seq_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic       rst;
        logic       req;
        logic       rail;
        logic [7:0] settle;
        logic [2:0] st;
        logic       done;
    } vec_t;

    typedef struct {
        logic [2:0]  st;
        logic        done;
        int unsigned id;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n_id  = 0;
    vec_t        tbl[28];

    // {switch, iso, clk_en, rst, ready, fault, seq_done, state}
    function automatic logic [9:0] exp_out(input logic [2:0] st, input logic done);
        logic [4:0] p;
        case (st)
            S_OFF:   p = 5'b01010;
            S_RAMP:  p = 5'b11010;
            S_RH:    p = 5'b11110;
            S_ON:    p = 5'b10101;
            S_ISO:   p = 5'b11100;
            S_DRN:   p = 5'b11010;
            S_DIS:   p = 5'b01010;
            default: p = 5'b01010;
        endcase
        return {p, (st == S_FLT), done, st};
    endfunction

    function automatic vec_t mkv(input logic rst, input logic req, input logic rail,
                                 input logic [7:0] settle, input logic [2:0] st,
                                 input logic done);
        vec_t v;
        v.rst = rst; v.req = req; v.rail = rail; v.settle = settle;
        v.st = st; v.done = done;
        return v;
    endfunction

    task automatic step(input logic rst, input logic req, input logic rail,
                        input logic [7:0] settle, input logic [2:0] st,
                        input logic done);
        exp_t e;
        @(negedge clock);
        reset            = rst;
        power_enable_req = req;
        rail_ok          = rail;
        settle_cycles    = settle;
        e.st   = st;
        e.done = done;
        e.id   = n_id;
        n_id++;
        sb.push_back(e);
    endtask

    // Power up from OFF with settle_cycles = 1 and rail good: 1 RAMP, 3 RESET_HOLD, ON.
    task automatic quick_up();
        step(0, 1, 1, 8'd1, S_RAMP, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 8'd1, S_RH, 0);
        step(0, 1, 1, 8'd1, S_ON, 1);
    endtask

    task automatic discharge_to_off(input logic req);
        for (int i = 0; i < 4; i++) step(0, req, 1, 8'd1, S_DIS, 0);
        step(0, 0, 1, 8'd1, S_OFF, 1);
    endtask

    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            exp_t       e;
            logic [9:0] got;
            logic [9:0] want;
            e    = sb.pop_front();
            want = exp_out(e.st, e.done);
            got  = {power_switch_en, isolation_en, domain_clk_en, domain_reset,
                    domain_ready, fault, seq_done, seq_state};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL step%0d sw/iso/clk/rst/rdy/flt/done/st got=%b want=%b",
                         e.id, got, want);
            end
        end
    end

    initial begin
        reset            = 1'b1;
        power_enable_req = 1'b0;
        settle_cycles    = 8'd4;
        rail_ok          = 1'b1;

        // Reset, power-up with settle 4, power-down, settle 0, reset from ON.
        tbl[0]  = mkv(1, 0, 1, 8'd4, S_OFF,  0);
        tbl[1]  = mkv(1, 0, 1, 8'd4, S_OFF,  0);
        tbl[2]  = mkv(0, 0, 1, 8'd4, S_OFF,  0);
        tbl[3]  = mkv(0, 1, 1, 8'd4, S_RAMP, 0);
        tbl[4]  = mkv(0, 1, 1, 8'd4, S_RAMP, 0);
        tbl[5]  = mkv(0, 1, 1, 8'd4, S_RAMP, 0);
        tbl[6]  = mkv(0, 1, 1, 8'd4, S_RAMP, 0);
        tbl[7]  = mkv(0, 1, 1, 8'd4, S_RH,   0);
        tbl[8]  = mkv(0, 1, 1, 8'd4, S_RH,   0);
        tbl[9]  = mkv(0, 1, 1, 8'd4, S_RH,   0);
        tbl[10] = mkv(0, 1, 1, 8'd4, S_ON,   1);
        tbl[11] = mkv(0, 1, 1, 8'd4, S_ON,   0);
        tbl[12] = mkv(0, 1, 1, 8'd4, S_ON,   0);
        tbl[13] = mkv(0, 0, 1, 8'd4, S_ISO,  0);
        tbl[14] = mkv(0, 0, 1, 8'd4, S_DRN,  0);
        tbl[15] = mkv(0, 0, 1, 8'd4, S_DIS,  0);
        tbl[16] = mkv(0, 0, 1, 8'd4, S_DIS,  0);
        tbl[17] = mkv(0, 0, 1, 8'd4, S_DIS,  0);
        tbl[18] = mkv(0, 0, 1, 8'd4, S_DIS,  0);
        tbl[19] = mkv(0, 0, 1, 8'd4, S_OFF,  1);
        tbl[20] = mkv(0, 0, 1, 8'd4, S_OFF,  0);
        tbl[21] = mkv(0, 1, 1, 8'd0, S_RAMP, 0);
        tbl[22] = mkv(0, 1, 1, 8'd0, S_RH,   0);
        tbl[23] = mkv(0, 1, 1, 8'd0, S_RH,   0);
        tbl[24] = mkv(0, 1, 1, 8'd0, S_RH,   0);
        tbl[25] = mkv(0, 1, 1, 8'd0, S_ON,   1);
        tbl[26] = mkv(1, 1, 1, 8'd0, S_OFF,  0);
        tbl[27] = mkv(0, 0, 1, 8'd0, S_OFF,  0);

        for (int i = 0; i < 28; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].rail, tbl[i].settle,
                 tbl[i].st, tbl[i].done);
        end

        // Ramp timeout: 64 cycles of RAMP with the rail never good, then FAULT.
        for (int i = 0; i < 64; i++) step(0, 1, 0, 8'd4, S_RAMP, 0);
        step(0, 1, 0, 8'd4, S_FLT, 0);
        step(0, 1, 0, 8'd4, S_FLT, 0);
        step(0, 1, 1, 8'd4, S_FLT, 0);
        discharge_to_off(0);

        // Brownout in ON: one low cycle of rail_ok latches FAULT until req drops.
        quick_up();
        step(0, 1, 1, 8'd1, S_ON, 0);
        step(0, 1, 0, 8'd1, S_FLT, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 8'd1, S_FLT, 0);
        discharge_to_off(0);

        // Abort during RAMP cycle 2: straight to DISCHARGE.
        step(0, 1, 1, 8'd4, S_RAMP, 0);
        step(0, 1, 1, 8'd4, S_RAMP, 0);
        discharge_to_off(0);

        // Abort during RESET_HOLD: DRAIN then DISCHARGE.
        step(0, 1, 1, 8'd1, S_RAMP, 0);
        step(0, 1, 1, 8'd1, S_RH, 0);
        step(0, 0, 1, 8'd1, S_DRN, 0);
        discharge_to_off(0);

        // Request re-rises during DISCHARGE: full discharge, one OFF cycle, RAMP.
        quick_up();
        step(0, 0, 1, 8'd1, S_ISO, 0);
        step(0, 0, 1, 8'd1, S_DRN, 0);
        step(0, 0, 1, 8'd1, S_DIS, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 8'd1, S_DIS, 0);
        step(0, 1, 1, 8'd1, S_OFF, 1);
        step(0, 1, 1, 8'd1, S_RAMP, 0);
        step(1, 0, 1, 8'd1, S_OFF, 0);

        // Let the checker drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
        #2;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
